// File: rtl/rtclock_core.sv
// rtclock_core: free-running seconds/nanoseconds time-of-day counter with load and PPS output
module rtclock_core #(
   parameter int unsigned C_NS_INC_INT  = 4,
   parameter int unsigned C_NS_INC_FRAC = 0,
   parameter int unsigned C_PPS_WIDTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] control_reg,
   input  logic [63:0] sec_config_reg,
   output logic [63:0] sec_state_reg,
   output logic [29:0] ns_state,
   output logic        sec_tick,
   output logic        pps_out,
   output logic        load_done
);
   localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
   localparam logic [31:0] NS_INC     = C_NS_INC_INT;
   localparam logic [15:0] FRAC_INC   = C_NS_INC_FRAC[15:0];
   localparam logic [7:0]  PPS_W      = C_PPS_WIDTH[7:0];

   logic        enable, load_req, pps_en, unused_ctrl;
   logic [15:0] frac_q, frac_d;
   logic [29:0] ns_q, ns_d;
   logic [63:0] sec_q, sec_d;
   logic        tick_q, tick_d;
   logic        req_q, req_d;
   logic        armed_q, armed_d;
   logic        pend_q, pend_d;
   logic        applied_q, applied_d;
   logic        done_q, done_d;
   logic [7:0]  pps_cnt_q, pps_cnt_d;
   logic [16:0] frac_sum;
   logic [31:0] ns_sum, ns_wrapped;
   logic        wrap;

   assign enable      = control_reg[0];
   assign load_req    = control_reg[1];
   assign pps_en      = control_reg[2];
   assign unused_ctrl = ^control_reg[31:3];

   // time advance, load priority, load_req edge pipeline and pps pulse counter
   always_comb begin
      frac_sum   = {1'b0, frac_q} + {1'b0, FRAC_INC};
      ns_sum     = {2'b00, ns_q} + NS_INC + {31'd0, frac_sum[16]};
      ns_wrapped = ns_sum - NS_PER_SEC;
      wrap       = ns_sum >= NS_PER_SEC;
      frac_d     = frac_q;
      ns_d       = ns_q;
      sec_d      = sec_q;
      tick_d     = 1'b0;
      if (pend_q) begin
         frac_d = '0;
         ns_d   = '0;
         sec_d  = sec_config_reg;
      end else if (enable) begin
         frac_d = frac_sum[15:0];
         ns_d   = wrap ? ns_wrapped[29:0] : ns_sum[29:0];
         sec_d  = sec_q + {63'd0, wrap};
         tick_d = wrap;
      end
      // armed_q blocks a level already high at reset release from looking like an edge
      req_d     = load_req;
      armed_d   = 1'b1;
      pend_d    = armed_q & load_req & ~req_q;
      applied_d = pend_q;
      done_d    = applied_q;
      pps_cnt_d = !pps_en ? 8'd0 : tick_q ? PPS_W : (pps_cnt_q != 8'd0) ? pps_cnt_q - 8'd1 : 8'd0;
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         frac_q    <= '0;
         ns_q      <= '0;
         sec_q     <= '0;
         tick_q    <= 1'b0;
         req_q     <= 1'b0;
         armed_q   <= 1'b0;
         pend_q    <= 1'b0;
         applied_q <= 1'b0;
         done_q    <= 1'b0;
         pps_cnt_q <= '0;
      end else begin
         frac_q    <= frac_d;
         ns_q      <= ns_d;
         sec_q     <= sec_d;
         tick_q    <= tick_d;
         req_q     <= req_d;
         armed_q   <= armed_d;
         pend_q    <= pend_d;
         applied_q <= applied_d;
         done_q    <= done_d;
         pps_cnt_q <= pps_cnt_d;
      end
   end

   assign sec_state_reg = sec_q;
   assign ns_state      = ns_q;
   assign sec_tick      = tick_q;
   assign pps_out       = pps_cnt_q != 8'd0;
   assign load_done     = done_q;
endmodule

// File: tb/tb_rtclock_core.sv
// tb_rtclock_core: randomized and directed checks of rtclock_core against a time-in-units reference model
module tb_rtclock_core;
   localparam int unsigned INT_M  = 300000000;
   localparam int unsigned FRAC_M = 32'h8001;
   localparam int unsigned PW     = 5;
   localparam longint unsigned INC_U = 64'(INT_M) * 64'd65536 + 64'(FRAC_M);
   localparam longint unsigned NS_SEC = 64'd1000000000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ctrl = '0;
   logic [31:0] ctrl_f = '0;
   logic [63:0] cfg = '0;
   logic [63:0] sec_o, sec_f;
   logic [29:0] ns_o, ns_f;
   logic        tick_o, pps_o, done_o, tick_f, pps_f, done_f;

   int total = 0;
   int bad = 0;

   // model: whole time since the last load in 2^-16 ns units on top of a loaded seconds base
   longint unsigned m_base, m_units;
   bit m_prev, m_armed, m_pend, m_applied, m_done, m_tick;
   int m_pps;

   always #5 clk = ~clk;

   rtclock_core #(.C_NS_INC_INT(INT_M), .C_NS_INC_FRAC(FRAC_M), .C_PPS_WIDTH(PW)) dut (
      .clk(clk), .reset(reset), .control_reg(ctrl), .sec_config_reg(cfg),
      .sec_state_reg(sec_o), .ns_state(ns_o), .sec_tick(tick_o), .pps_out(pps_o), .load_done(done_o));

   rtclock_core #(.C_NS_INC_INT(6), .C_NS_INC_FRAC(32'h6666), .C_PPS_WIDTH(8)) dut_f (
      .clk(clk), .reset(reset), .control_reg(ctrl_f), .sec_config_reg(64'd0),
      .sec_state_reg(sec_f), .ns_state(ns_f), .sec_tick(tick_f), .pps_out(pps_f), .load_done(done_f));

   function automatic longint unsigned m_sec();
      return m_base + (m_units >> 16) / NS_SEC;
   endfunction

   function automatic longint unsigned m_ns();
      return (m_units >> 16) % NS_SEC;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock: advance the model from the inputs seen at the edge, then compare all outputs
   task automatic step();
      longint unsigned old;
      @(posedge clk);
      if (reset) begin
         m_base = 0; m_units = 0; m_prev = 0; m_armed = 0;
         m_pend = 0; m_applied = 0; m_done = 0; m_tick = 0; m_pps = 0;
      end else begin
         m_pps = !ctrl[2] ? 0 : m_tick ? int'(PW) : (m_pps > 0 ? m_pps - 1 : 0);
         m_done = m_applied;
         m_applied = m_pend;
         if (m_pend) begin
            m_base = cfg; m_units = 0; m_tick = 0;
         end else if (ctrl[0]) begin
            old = m_sec();
            m_units += INC_U;
            m_tick = m_sec() != old;
         end else m_tick = 0;
         m_pend = m_armed && ctrl[1] && !m_prev;
         m_prev = ctrl[1];
         m_armed = 1;
      end
      #1;
      check("sec", sec_o, m_sec());
      check("ns", {34'd0, ns_o}, m_ns());
      check("tick", {63'd0, tick_o}, {63'd0, m_tick});
      check("pps", {63'd0, pps_o}, {63'd0, m_pps != 0});
      check("done", {63'd0, done_o}, {63'd0, m_done});
   endtask

   task automatic wait_tick(input string tag);
      int n;
      n = 0;
      while (!m_tick && n < 40) begin step(); n++; end
      if (!m_tick) check(tag, 64'd0, 64'd1);
   endtask

   initial begin
      longint unsigned frozen_ns, frozen_sec;
      // reset with load_req held high throughout; release must not cause a load
      cfg = 64'hDEAD_BEEF_0000_0001;
      ctrl = 32'h2;
      repeat (3) step();
      check("rst_sec", sec_o, 64'd0);
      check("rst_pps", {63'd0, pps_o}, 64'd0);
      reset = 1'b0;
      ctrl = 32'h7;
      repeat (10) step();
      check("no_load_after_rst", {63'd0, sec_o == cfg}, 64'd0);
      // single load, then held level gives no second load
      ctrl = 32'h5; step();
      cfg = 64'h0000_0000_6553_F100;
      ctrl = 32'h7; step(); step();
      check("load_sec", sec_o, 64'h6553F100);
      check("load_ns", {34'd0, ns_o}, 64'd0);
      cfg = 64'h1111;
      step();
      check("load_done", {63'd0, done_o}, 64'd1);
      repeat (20) step();
      // load landing on the wrap cycle wins and suppresses the tick
      ctrl = 32'h5; step();
      cfg = '1;
      ctrl = 32'h7; step(); step();
      ctrl = 32'h5; step(); step();
      ctrl = 32'h7; step(); step();
      check("coll_sec", sec_o, 64'hFFFF_FFFF_FFFF_FFFF);
      check("coll_tick", {63'd0, tick_o}, 64'd0);
      repeat (4) step();
      check("wrap_sec", sec_o, 64'd0);
      check("wrap_tick", {63'd0, tick_o}, 64'd1);
      // enable low: everything frozen
      ctrl = 32'h6;
      frozen_ns = m_ns(); frozen_sec = m_sec();
      repeat (100) step();
      check("frozen_ns", {34'd0, ns_o}, frozen_ns);
      check("frozen_sec", sec_o, frozen_sec);
      // pps_en dropped at pulse cycle 3
      ctrl = 32'h7;
      wait_tick("tick_wait1");
      repeat (3) step();
      check("pps_mid", {63'd0, pps_o}, 64'd1);
      ctrl = 32'h3; step();
      check("pps_drop", {63'd0, pps_o}, 64'd0);
      // reset during a pulse with a load pending
      ctrl = 32'h7;
      cfg = 64'h1234_5678;
      wait_tick("tick_wait2");
      ctrl = 32'h5; step();
      ctrl = 32'h7; step();
      reset = 1'b1; step();
      check("mid_rst_sec", sec_o, 64'd0);
      check("mid_rst_pps", {63'd0, pps_o}, 64'd0);
      reset = 1'b0;
      repeat (6) step();
      check("mid_rst_no_load", {63'd0, sec_o == cfg}, 64'd0);
      // randomized operation
      for (int i = 0; i < 3000; i++) begin
         ctrl[31:3] = 29'($urandom);
         ctrl[0] = $urandom_range(0, 9) < 8;
         if ($urandom_range(0, 9) == 0) ctrl[1] = ~ctrl[1];
         ctrl[2] = $urandom_range(0, 9) < 9;
         if ($urandom_range(0, 7) == 0) cfg = $urandom_range(0, 2) == 0 ? '1 : {$urandom, $urandom};
         reset = $urandom_range(0, 199) == 0;
         step();
      end
      // fractional increment instance: 1000 enabled cycles
      reset = 1'b1; step();
      reset = 1'b0;
      ctrl_f = 32'h1;
      repeat (1000) step();
      ctrl_f = 32'h0;
      check("frac_ns", {34'd0, ns_f}, (64'd1000 * (64'd6 * 64'd65536 + 64'h6666)) >> 16);
      check("frac_sec", sec_f, 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
